// File: rtl/total_exponent_pipe_pkg.sv
// Shared types and width helpers for the total-exponent pipeline.
// Width helpers derive K_W/TE_W/ES_W from the posit parameters.
package total_exponent_pipe_pkg;

  function automatic int unsigned k_w(int unsigned n);
    return $clog2(n) + 1;
  endfunction

  function automatic int unsigned te_w(int unsigned n, int unsigned es_max);
    return k_w(n) + es_max;
  endfunction

  // One spare bit so an out-of-range es can actually be presented and flagged.
  function automatic int unsigned es_w(int unsigned es_max);
    return $clog2(es_max + 1) + 1;
  endfunction

  typedef enum logic {
    TE_COMPOSE   = 1'b0,
    TE_DECOMPOSE = 1'b1
  } te_mode_t;

  localparam int unsigned PpuN     = 16;
  localparam int unsigned PpuEsMax = 3;
  localparam int unsigned PpuTagW  = 4;
  localparam int unsigned PpuKW    = k_w(PpuN);
  localparam int unsigned PpuTeW   = te_w(PpuN, PpuEsMax);
  localparam int unsigned PpuEsW   = es_w(PpuEsMax);

  // Transaction records for the default datapath configuration.
  typedef struct packed {
    te_mode_t              mode;
    logic [PpuEsW-1:0]     es;
    logic [PpuKW-1:0]      k;
    logic [PpuEsMax-1:0]   exp;
    logic [PpuTeW-1:0]     te;
    logic [PpuTagW-1:0]    tag;
  } te_req_t;

  typedef struct packed {
    logic [PpuTeW-1:0]     te;
    logic [PpuKW-1:0]      k;
    logic [PpuEsMax-1:0]   exp;
    logic                  ovf;
    logic                  esbad;
    logic [PpuTagW-1:0]    tag;
  } te_rsp_t;

endpackage

// File: rtl/total_exponent_pipe_if.sv
// Request/response valid-ready bundle of the total-exponent pipeline.
// master = producer/consumer side, slave = the pipeline itself.
interface total_exponent_pipe_if
  import total_exponent_pipe_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned ES_MAX = 3,
  parameter int unsigned TAG_W  = 4
) ();

  localparam int unsigned K_W  = k_w(N);
  localparam int unsigned TE_W = te_w(N, ES_MAX);
  localparam int unsigned ES_W = es_w(ES_MAX);

  logic              in_valid_i;
  logic              in_ready_o;
  logic              mode_i;
  logic [ES_W-1:0]   es_i;
  logic [K_W-1:0]    k_i;
  logic [ES_MAX-1:0] exp_i;
  logic [TE_W-1:0]   te_i;
  logic [TAG_W-1:0]  tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [TE_W-1:0]   te_o;
  logic [K_W-1:0]    k_o;
  logic [ES_MAX-1:0] exp_o;
  logic              ovf_o;
  logic              esbad_o;
  logic [TAG_W-1:0]  tag_o;

  modport master (
    output in_valid_i, mode_i, es_i, k_i, exp_i, te_i, tag_i, out_ready_i,
    input  in_ready_o, out_valid_o, te_o, k_o, exp_o, ovf_o, esbad_o, tag_o
  );

  modport slave (
    input  in_valid_i, mode_i, es_i, k_i, exp_i, te_i, tag_i, out_ready_i,
    output in_ready_o, out_valid_o, te_o, k_o, exp_o, ovf_o, esbad_o, tag_o
  );

endinterface

// File: rtl/total_exponent_pipe_reg.sv
// Valid/ready register slice with async reset and synchronous flush.
// A flush always reports ready so upstream never stalls on a dying pipe.
module te_pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  logic             r_valid;
  logic [Width-1:0] r_data;

  assign ready_o = flush_i || !r_valid || ready_i;
  assign valid_o = r_valid;
  assign data_o  = r_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (ready_o) begin
      r_valid <= valid_i;
      if (valid_i) r_data <= data_i;
    end
  end

endmodule

// File: rtl/total_exponent_pipe.sv
// Two-stage runtime-es total-exponent unit: compose te = k*2^es + exp,
// decompose te -> (k, exp) with k saturation. S1 captures/masks, S2 computes.
module total_exponent_pipe
  import total_exponent_pipe_pkg::*;
#(
  parameter int unsigned N      = 16,
  parameter int unsigned ES_MAX = 3,
  parameter int unsigned TAG_W  = 4
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  input logic                  flush_i,
  total_exponent_pipe_if.slave bus
);

  localparam int unsigned K_W  = k_w(N);
  localparam int unsigned TE_W = te_w(N, ES_MAX);
  localparam int unsigned ES_W = es_w(ES_MAX);

  localparam logic signed [TE_W-1:0] KMax = TE_W'((2 ** (K_W - 1)) - 1);
  localparam logic signed [TE_W-1:0] KMin = ~KMax;

  typedef struct packed {
    te_mode_t          mode;
    logic [ES_W-1:0]   es;
    logic              esbad;
    logic [ES_MAX-1:0] mask;
    logic [K_W-1:0]    k;
    logic [ES_MAX-1:0] exp;
    logic [TE_W-1:0]   te;
    logic [TAG_W-1:0]  tag;
  } s1_t;

  typedef struct packed {
    logic [TE_W-1:0]   te;
    logic [K_W-1:0]    k;
    logic [ES_MAX-1:0] exp;
    logic              ovf;
    logic              esbad;
    logic [TAG_W-1:0]  tag;
  } s2_t;

  logic              w_esbad;
  logic [ES_W-1:0]   w_es;
  logic [ES_MAX-1:0] w_mask;
  s1_t               w_s1_in, w_s1_out;
  logic              w_s1_valid, w_s2_ready, w_s2_valid;
  s2_t               w_s2_in, w_s2_out;

  assign w_esbad = bus.es_i > ES_W'(ES_MAX);
  assign w_es    = w_esbad ? ES_W'(ES_MAX) : bus.es_i;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < int'(ES_MAX); i++) w_mask[i] = (i < int'(w_es));
  end

  always_comb begin
    w_s1_in       = '0;
    w_s1_in.mode  = te_mode_t'(bus.mode_i);
    w_s1_in.es    = w_es;
    w_s1_in.esbad = w_esbad;
    w_s1_in.mask  = w_mask;
    w_s1_in.k     = bus.k_i;
    w_s1_in.exp   = bus.exp_i & w_mask;
    w_s1_in.te    = bus.te_i;
    w_s1_in.tag   = bus.tag_i;
  end

  te_pipe_reg #(.Width($bits(s1_t))) u_s1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (bus.in_valid_i),
    .ready_o (bus.in_ready_o),
    .data_i  (w_s1_in),
    .valid_o (w_s1_valid),
    .ready_i (w_s2_ready),
    .data_o  (w_s1_out)
  );

  logic [TE_W-1:0]        w_k_ext;
  logic [TE_W-1:0]        w_compose;
  logic signed [TE_W-1:0] w_kf;

  assign w_k_ext   = {{ES_MAX{w_s1_out.k[K_W-1]}}, w_s1_out.k};
  assign w_compose = (w_k_ext << w_s1_out.es) + {{K_W{1'b0}}, w_s1_out.exp};
  assign w_kf      = $signed(w_s1_out.te) >>> w_s1_out.es;

  always_comb begin
    w_s2_in       = '0;
    w_s2_in.esbad = w_s1_out.esbad;
    w_s2_in.tag   = w_s1_out.tag;
    if (w_s1_out.mode == TE_COMPOSE) begin
      w_s2_in.te = w_compose;
    end else if (w_kf > KMax) begin
      w_s2_in.k   = KMax[K_W-1:0];
      w_s2_in.exp = w_s1_out.mask;
      w_s2_in.ovf = 1'b1;
    end else if (w_kf < KMin) begin
      w_s2_in.k   = KMin[K_W-1:0];
      w_s2_in.ovf = 1'b1;
    end else begin
      w_s2_in.k   = w_kf[K_W-1:0];
      w_s2_in.exp = w_s1_out.te[ES_MAX-1:0] & w_s1_out.mask;
    end
  end

  te_pipe_reg #(.Width($bits(s2_t))) u_s2 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .valid_i (w_s1_valid),
    .ready_o (w_s2_ready),
    .data_i  (w_s2_in),
    .valid_o (w_s2_valid),
    .ready_i (bus.out_ready_i),
    .data_o  (w_s2_out)
  );

  assign bus.out_valid_o = w_s2_valid;
  assign bus.te_o        = w_s2_out.te;
  assign bus.k_o         = w_s2_out.k;
  assign bus.exp_o       = w_s2_out.exp;
  assign bus.ovf_o       = w_s2_out.ovf;
  assign bus.esbad_o     = w_s2_out.esbad;
  assign bus.tag_o       = w_s2_out.tag;

endmodule

// File: tb/tb_total_exponent_pipe.sv
// Self-checking bench for total_exponent_pipe (N=16, ES_MAX=3: K_W=5, TE_W=8).
// Directed table, random stream against an integer-arithmetic model, flush/reset cases.
module tb_total_exponent_pipe;

  typedef struct packed {
    logic       mode;
    logic [2:0] es;
    logic [4:0] k;
    logic [2:0] exp;
    logic [7:0] te;
    logic [3:0] tag;
  } txn_t;

  typedef struct packed {
    logic [7:0] te;
    logic [4:0] k;
    logic [2:0] exp;
    logic       ovf;
    logic       esbad;
    logic [3:0] tag;
  } res_t;

  typedef struct packed {
    txn_t in;
    res_t want;
  } vec_t;

  logic clk;
  logic rst_ni;
  logic flush;
  int   n_checks = 0;
  int   n_fail   = 0;

  total_exponent_pipe_if #(.N(16), .ES_MAX(3), .TAG_W(4)) bus ();

  total_exponent_pipe #(.N(16), .ES_MAX(3), .TAG_W(4)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic with floor division.
  function automatic res_t model(txn_t t);
    res_t r;
    int es, d, kv, tv, kf, e;
    r       = '0;
    r.tag   = t.tag;
    r.esbad = (t.es > 3);
    es      = (t.es > 3) ? 3 : int'(t.es);
    d       = 2 ** es;
    if (!t.mode) begin
      kv = int'(t.k);
      if (kv >= 16) kv -= 32;
      e    = int'(t.exp) % d;
      tv   = kv * d + e;
      r.te = 8'(tv);
    end else begin
      tv = int'(t.te);
      if (tv >= 128) tv -= 256;
      kf = (tv >= 0) ? tv / d : -((-tv + d - 1) / d);
      e  = tv - kf * d;
      if (kf > 15) begin
        r.k = 5'd15; r.exp = 3'(d - 1); r.ovf = 1'b1;
      end else if (kf < -16) begin
        r.k = 5'h10; r.exp = 3'd0; r.ovf = 1'b1;
      end else begin
        r.k = 5'(kf); r.exp = 3'(e);
      end
    end
    return r;
  endfunction

  function automatic res_t got();
    return {bus.te_o, bus.k_o, bus.exp_o, bus.ovf_o, bus.esbad_o, bus.tag_o};
  endfunction

  task automatic check(input string name, input res_t want);
    res_t g;
    g = got();
    n_checks++;
    if (g !== want) begin
      n_fail++;
      $display("FAIL %s: got te=%h k=%h exp=%h ovf=%b esbad=%b tag=%h, want te=%h k=%h exp=%h ovf=%b esbad=%b tag=%h",
               name, g.te, g.k, g.exp, g.ovf, g.esbad, g.tag,
               want.te, want.k, want.exp, want.ovf, want.esbad, want.tag);
    end
  endtask

  task automatic chk_int(input string name, input int g, input int want);
    n_checks++;
    if (g !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, g, want);
    end
  endtask

  task automatic set_in(input txn_t t);
    bus.mode_i = t.mode;
    bus.es_i   = t.es;
    bus.k_i    = t.k;
    bus.exp_i  = t.exp;
    bus.te_i   = t.te;
    bus.tag_i  = t.tag;
  endtask

  function automatic txn_t rand_txn(input logic [3:0] tag);
    txn_t t;
    t.mode = 1'($urandom_range(0, 1));
    t.es   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
    t.k    = 5'($urandom);
    t.exp  = 3'($urandom);
    t.te   = 8'($urandom);
    t.tag  = tag;
    return t;
  endfunction

  function automatic vec_t mk(input logic m, input logic [2:0] es, input logic [4:0] k,
                              input logic [2:0] e, input logic [7:0] te, input logic [3:0] tag,
                              input logic [7:0] w_te, input logic [4:0] w_k,
                              input logic [2:0] w_e, input logic w_ovf, input logic w_bad);
    vec_t v;
    v.in   = {m, es, k, e, te, tag};
    v.want = {w_te, w_k, w_e, w_ovf, w_bad, tag};
    return v;
  endfunction

  task automatic run_stream(input bit burst, input int target, input int budget);
    res_t q[$];
    txn_t t;
    int   sent = 0;
    int   cyc  = 0;
    while ((sent < target || q.size() != 0) && cyc < budget) begin
      @(negedge clk);
      t = rand_txn(4'(sent));
      set_in(t);
      bus.in_valid_i  = (sent < target) && (burst || $urandom_range(0, 3) != 0);
      bus.out_ready_i = burst ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid_o) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL stream_dup: got output tag=%h want no output", bus.tag_o);
        end else begin
          check(burst ? "burst_data" : "random_data", q[0]);
          if (bus.out_ready_i) q.delete(0);
        end
      end
      if (bus.in_valid_i && bus.in_ready_o) begin
        q.push_back(model(t));
        sent++;
      end
      cyc++;
    end
    bus.in_valid_i = 1'b0;
    chk_int("stream_drained", q.size() + (target - sent), 0);
  endtask

  task automatic fill_pipe(output txn_t first);
    @(negedge clk);
    first = rand_txn(4'hA);
    set_in(first);
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b0;
    @(negedge clk);
    set_in(rand_txn(4'hB));
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    #1 chk_int("fill_out_valid", int'(bus.out_valid_o), 1);
  endtask

  vec_t vecs[13];
  txn_t f0;

  initial begin
    vecs[0]  = mk(0, 2, 5'h1D, 3'd1, 8'hA5, 4'h1, 8'hF5, 5'h00, 3'd0, 0, 0);
    vecs[1]  = mk(1, 2, 5'h0A, 3'd5, 8'hF5, 4'h2, 8'h00, 5'h1D, 3'd1, 0, 0);
    vecs[2]  = mk(1, 0, 5'h0A, 3'd5, 8'h64, 4'h3, 8'h00, 5'h0F, 3'd0, 1, 0);
    vecs[3]  = mk(1, 0, 5'h0A, 3'd5, 8'h9C, 4'h4, 8'h00, 5'h10, 3'd0, 1, 0);
    vecs[4]  = mk(0, 5, 5'h01, 3'd7, 8'h3C, 4'h5, 8'h0F, 5'h00, 3'd0, 0, 1);
    vecs[5]  = mk(0, 0, 5'h10, 3'd7, 8'h11, 4'h6, 8'hF0, 5'h00, 3'd0, 0, 0);
    vecs[6]  = mk(0, 3, 5'h10, 3'd0, 8'h22, 4'h7, 8'h80, 5'h00, 3'd0, 0, 0);
    vecs[7]  = mk(0, 3, 5'h0F, 3'd7, 8'h33, 4'h8, 8'h7F, 5'h00, 3'd0, 0, 0);
    vecs[8]  = mk(1, 3, 5'h0A, 3'd5, 8'h7F, 4'h9, 8'h00, 5'h0F, 3'd7, 0, 0);
    vecs[9]  = mk(1, 3, 5'h0A, 3'd5, 8'h80, 4'hA, 8'h00, 5'h10, 3'd0, 0, 0);
    vecs[10] = mk(1, 2, 5'h0A, 3'd5, 8'h7F, 4'hB, 8'h00, 5'h0F, 3'd3, 1, 0);
    vecs[11] = mk(1, 7, 5'h0A, 3'd5, 8'h80, 4'hC, 8'h00, 5'h10, 3'd0, 0, 1);
    vecs[12] = mk(0, 1, 5'h02, 3'd6, 8'h44, 4'hD, 8'h04, 5'h00, 3'd0, 0, 0);

    rst_ni          = 1'b0;
    flush           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    set_in('0);
    #3;
    chk_int("reset_out_valid", int'(bus.out_valid_o), 0);
    chk_int("reset_in_ready", int'(bus.in_ready_o), 1);
    check("reset_outputs", '0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Directed table: two-cycle latency and exact results.
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      set_in(vecs[i].in);
      bus.in_valid_i  = 1'b1;
      bus.out_ready_i = 1'b1;
      #1 chk_int("vec_in_ready", int'(bus.in_ready_o), 1);
      @(negedge clk);
      bus.in_valid_i = 1'b0;
      set_in(rand_txn(4'hF));
      #1 chk_int("vec_lat1_valid", int'(bus.out_valid_o), 0);
      @(negedge clk);
      #1 chk_int("vec_lat2_valid", int'(bus.out_valid_o), 1);
      check($sformatf("vec%0d", i), vecs[i].want);
    end

    run_stream(1'b1, 8, 200);
    run_stream(1'b0, 300, 3000);

    // Flush with a stalled full pipe: drop everything, including same-cycle input.
    fill_pipe(f0);
    @(negedge clk);
    flush          = 1'b1;
    bus.in_valid_i = 1'b1;
    set_in(rand_txn(4'h5));
    #1 chk_int("flush_in_ready", int'(bus.in_ready_o), 1);
    @(negedge clk);
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    #1 chk_int("flush_out_valid", int'(bus.out_valid_o), 0);
    chk_int("post_flush_in_ready", int'(bus.in_ready_o), 1);
    @(negedge clk);
    #1 chk_int("flush_dropped_input", int'(bus.out_valid_o), 0);

    // Flush together with out_ready: current output is handed over, then empty.
    fill_pipe(f0);
    @(negedge clk);
    flush           = 1'b1;
    bus.out_ready_i = 1'b1;
    #1 chk_int("flush_hs_valid", int'(bus.out_valid_o), 1);
    check("flush_hs_data", model(f0));
    @(negedge clk);
    flush           = 1'b0;
    bus.out_ready_i = 1'b0;
    #1 chk_int("flush_hs_empty", int'(bus.out_valid_o), 0);

    // Asynchronous reset in mid-cycle with a full pipe.
    fill_pipe(f0);
    #2 rst_ni = 1'b0;
    #1 chk_int("areset_out_valid", int'(bus.out_valid_o), 0);
    chk_int("areset_in_ready", int'(bus.in_ready_o), 1);
    check("areset_outputs", '0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1 chk_int("post_reset_empty", int'(bus.out_valid_o), 0);

    run_stream(1'b0, 20, 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
